// File: rtl/cla_serial_adder.sv
// Multi-cycle WIDTH-bit adder/subtractor: one 4-bit carry-lookahead slice per clock,
// LSB slice first, with a registered carry between slices and registered result flags.
module cla_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Overflow,
  output logic             Zero,
  output logic [1:0]       o_dbg_state
);

  localparam int NSLICE = WIDTH / 4;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;
  logic             r_zero;

  logic             w_accept;
  logic             w_last;
  logic [3:0]       w_sa;
  logic [3:0]       w_sb;
  logic [3:0]       w_g;
  logic [3:0]       w_p;
  logic [4:0]       w_c;
  logic [3:0]       w_s;
  logic [WIDTH-1:0] w_acc_next;

  // A new operation is taken from IDLE or straight out of DONE (back-to-back).
  assign w_accept = start && (r_state == IDLE || r_state == DONE);
  assign w_last   = (r_cnt == CW'(NSLICE - 1));

  assign w_sa = r_a[{r_cnt, 2'b00} +: 4];
  assign w_sb = r_b[{r_cnt, 2'b00} +: 4];
  assign w_g  = w_sa & w_sb;
  assign w_p  = w_sa ^ w_sb;

  // Carry-lookahead: every slice carry is a flat function of g/p and the slice carry-in.
  assign w_c[0] = r_carry;
  assign w_c[1] = w_g[0] | (w_p[0] & w_c[0]);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_c[0]);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & w_c[0]);
  assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_c[0]);
  assign w_s    = w_p ^ w_c[3:0];

  always_comb begin
    w_acc_next = r_acc;
    w_acc_next[{r_cnt, 2'b00} +: 4] = w_s;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_next = RUN;
      RUN:     if (w_last)   w_state_next = DONE;
      DONE:    w_state_next = w_accept ? RUN : IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_zero  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_a     <= A;
        r_b     <= Sub ? ~B : B;
        r_carry <= Sub ? 1'b1 : Cin;
        r_cnt   <= '0;
      end else if (r_state == RUN) begin
        r_acc   <= w_acc_next;
        r_carry <= w_c[4];
        r_cnt   <= r_cnt + 1'b1;
        // Results are published only once the final slice is in.
        if (w_last) begin
          r_sum  <= w_acc_next;
          r_cout <= w_c[4];
          r_ovf  <= w_c[3] ^ w_c[4];
          r_zero <= (w_acc_next == '0);
        end
      end
    end
  end

  assign busy        = (r_state == RUN);
  assign done        = (r_state == DONE);
  assign Sum         = r_sum;
  assign Cout        = r_cout;
  assign Overflow    = r_ovf;
  assign Zero        = r_zero;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_cla_serial_adder.sv
// Bench for cla_serial_adder: directed handshake/flag scenarios on a 16-bit instance,
// exhaustive 4-bit add sweep, and random back-to-back add/sub against an arithmetic model.
module tb_cla_serial_adder;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        sub;
  logic        busy;
  logic        done;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;
  logic        zero;
  logic [1:0]  dbg_state;

  logic        start4;
  logic [3:0]  a4;
  logic [3:0]  b4;
  logic        cin4;
  logic        sub4;
  logic        busy4;
  logic        done4;
  logic [3:0]  sum4;
  logic        cout4;
  logic        ovf4;
  logic        zero4;
  logic [1:0]  dbg_state4;

  int total;
  int bad;
  logic [18:0] exp_q[$];

  cla_serial_adder #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .A(a), .B(b), .Cin(cin), .Sub(sub),
    .busy(busy), .done(done), .Sum(sum), .Cout(cout), .Overflow(ovf), .Zero(zero),
    .o_dbg_state(dbg_state)
  );

  cla_serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .A(a4), .B(b4), .Cin(cin4), .Sub(sub4),
    .busy(busy4), .done(done4), .Sum(sum4), .Cout(cout4), .Overflow(ovf4), .Zero(zero4),
    .o_dbg_state(dbg_state4)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {Cout, Overflow, Zero, Sum} from plain two's-complement arithmetic.
  function automatic logic [18:0] model16(input logic [15:0] x, input logic [15:0] y,
                                          input logic c, input logic s);
    logic [15:0] yy;
    logic [16:0] t;
    logic        v;
    yy = s ? ~y : y;
    t  = {1'b0, x} + {1'b0, yy} + {16'd0, (s ? 1'b1 : c)};
    v  = (x[15] == yy[15]) && (t[15] != x[15]);
    return {t[16], v, (t[15:0] == 16'd0), t[15:0]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [15:0] x, input logic [15:0] y,
                          input logic c, input logic s);
    a = x; b = y; cin = c; sub = s; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Advances until done (bounded); reports the cycle index of done and whether busy was
  // high on every cycle before it and low on the done cycle.
  task automatic wait_done(input int first_cyc, input bit scramble, output int cyc,
                           output bit busy_ok, output bit timed_out);
    cyc = first_cyc;
    busy_ok = 1'b1;
    while (!done && cyc < 40) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (scramble) begin
        a = 16'($urandom); b = 16'($urandom);
        cin = 1'($urandom); sub = 1'($urandom);
        start = 1'($urandom);
      end
      step();
      cyc++;
    end
    start = 1'b0;
    timed_out = (done !== 1'b1);
    if (busy !== 1'b0) busy_ok = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; a = 16'hABCD; b = 16'h1234; cin = 1'b1; sub = 1'b0;
    step();
    step();
    total++;
    if ({busy, done, sum, cout, ovf, zero} !== 20'd0) begin
      bad++;
      $display("FAIL reset_outputs: got busy=%b done=%b sum=%h c=%b v=%b z=%b, want all 0",
               busy, done, sum, cout, ovf, zero);
    end
    rst = 1'b0; start = 1'b0;
    step();
    total++;
    if ({busy, done} !== 2'b00) begin
      bad++;
      $display("FAIL reset_no_start: got busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  task automatic test_add();
    int cyc; bit bok; bit to;
    start_op(16'h00FF, 16'h0001, 1'b0, 1'b0);
    wait_done(1, 1'b0, cyc, bok, to);
    total++;
    if (to || cyc != 5 || !bok) begin
      bad++;
      $display("FAIL add_latency: got done_cycle=%0d busy_ok=%0d timeout=%0d, want 5 1 0",
               cyc, bok, to);
    end
    total++;
    if ({cout, ovf, zero, sum} !== {3'b000, 16'h0100}) begin
      bad++;
      $display("FAIL add_result: got sum=%h c=%b v=%b z=%b, want 0100 0 0 0", sum, cout, ovf, zero);
    end
    step();
    total++;
    if ({busy, done} !== 2'b00 || sum !== 16'h0100) begin
      bad++;
      $display("FAIL add_done_pulse: got busy=%b done=%b sum=%h, want 0 0 0100", busy, done, sum);
    end
  endtask

  task automatic test_wrap_sub();
    int cyc; bit bok; bit to;
    start_op(16'hFFFF, 16'h0000, 1'b1, 1'b0);
    wait_done(1, 1'b0, cyc, bok, to);
    total++;
    if (to || {cout, ovf, zero, sum} !== {3'b101, 16'h0000}) begin
      bad++;
      $display("FAIL wrap: got sum=%h c=%b v=%b z=%b to=%0d, want 0000 1 0 1", sum, cout, ovf, zero, to);
    end
    step();
    start_op(16'h7FFF, 16'hFFFF, 1'b0, 1'b1);
    wait_done(1, 1'b0, cyc, bok, to);
    total++;
    if (to || {cout, ovf, zero, sum} !== {3'b010, 16'h8000}) begin
      bad++;
      $display("FAIL sub_ovf: got sum=%h c=%b v=%b z=%b to=%0d, want 8000 0 1 0", sum, cout, ovf, zero, to);
    end
    step();
  endtask

  task automatic test_ignore_start();
    int cyc; bit bok; bit to;
    start_op(16'h0F0F, 16'h0101, 1'b0, 1'b0);
    step();
    a = 16'h1111; start = 1'b1;
    step();
    start = 1'b0;
    wait_done(3, 1'b0, cyc, bok, to);
    total++;
    if (to || cyc != 5 || sum !== 16'h1010) begin
      bad++;
      $display("FAIL ignore_start: got done_cycle=%0d sum=%h to=%0d, want 5 1010 0", cyc, sum, to);
    end
    step();
    step();
    total++;
    if ({busy, done} !== 2'b00 || sum !== 16'h1010) begin
      bad++;
      $display("FAIL ignore_start_idle: got busy=%b done=%b sum=%h, want 0 0 1010", busy, done, sum);
    end
  endtask

  task automatic test_back_to_back();
    int cyc; bit bok; bit to;
    start_op(16'h0001, 16'h0001, 1'b0, 1'b0);
    wait_done(1, 1'b0, cyc, bok, to);
    total++;
    if (to || sum !== 16'h0002) begin
      bad++;
      $display("FAIL b2b_first: got sum=%h to=%0d, want 0002 0", sum, to);
    end
    start_op(16'h0002, 16'h0003, 1'b0, 1'b0);
    wait_done(1, 1'b0, cyc, bok, to);
    total++;
    if (to || cyc != 5 || !bok || sum !== 16'h0005) begin
      bad++;
      $display("FAIL b2b_second: got done_cycle=%0d busy_ok=%0d sum=%h to=%0d, want 5 1 0005 0",
               cyc, bok, sum, to);
    end
    step();
  endtask

  task automatic test_reset_mid();
    int seen_done;
    start_op(16'h1234, 16'h1111, 1'b0, 1'b0);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++;
    if ({busy, done} !== 2'b00 || sum !== 16'h0000) begin
      bad++;
      $display("FAIL reset_mid: got busy=%b done=%b sum=%h, want 0 0 0000", busy, done, sum);
    end
    seen_done = 0;
    for (int i = 0; i < 10; i++) begin
      if (done === 1'b1) seen_done++;
      step();
    end
    total++;
    if (seen_done != 0 || sum !== 16'h0000) begin
      bad++;
      $display("FAIL reset_mid_no_done: got done_pulses=%0d sum=%h, want 0 0000", seen_done, sum);
    end
  endtask

  task automatic test_width4_exhaustive();
    logic [4:0] exp;
    sub4 = 1'b0;
    for (int i = 0; i < 512; i++) begin
      a4 = 4'(i >> 5); b4 = 4'(i >> 1); cin4 = 1'(i);
      exp = {1'b0, a4} + {1'b0, b4} + {4'd0, cin4};
      start4 = 1'b1;
      step();
      start4 = 1'b0;
      step();
      total++;
      if (done4 !== 1'b1 || {cout4, sum4} !== exp) begin
        bad++;
        $display("FAIL w4_add a=%h b=%h c=%b: got done=%b cout=%b sum=%h, want 1 %b %h",
                 a4, b4, cin4, done4, cout4, sum4, exp[4], exp[3:0]);
      end
    end
    step();
  endtask

  task automatic test_random();
    int cyc; bit bok; bit to;
    logic [15:0] x; logic [15:0] y; logic c; logic s;
    logic [18:0] exp;
    x = 16'($urandom); y = 16'($urandom); c = 1'($urandom); s = 1'($urandom);
    exp_q.push_back(model16(x, y, c, s));
    start_op(x, y, c, s);
    for (int n = 0; n < 1000; n++) begin
      wait_done(1, 1'b1, cyc, bok, to);
      total++;
      if (to || cyc != 5 || !bok) begin
        bad++;
        $display("FAIL rand_timing op%0d: got done_cycle=%0d busy_ok=%0d to=%0d, want 5 1 0",
                 n, cyc, bok, to);
        if (to) break;
      end
      exp = exp_q.pop_front();
      total++;
      if ({cout, ovf, zero, sum} !== exp) begin
        bad++;
        $display("FAIL rand_result op%0d: got c=%b v=%b z=%b sum=%h, want c=%b v=%b z=%b sum=%h",
                 n, cout, ovf, zero, sum, exp[18], exp[17], exp[16], exp[15:0]);
      end
      if (n < 999) begin
        x = 16'($urandom); y = 16'($urandom); c = 1'($urandom); s = 1'($urandom);
        if ($urandom_range(0, 3) == 0) begin
          x = {x[15], 15'h7FFF};
          if ($urandom_range(0, 1) == 0) y = ~x;
        end
        exp_q.push_back(model16(x, y, c, s));
        if ($urandom_range(0, 3) == 0) step();
        start_op(x, y, c, s);
      end
    end
    step();
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0; sub4 = 1'b0;
    #1;
    test_reset();
    test_add();
    test_wrap_sub();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_width4_exhaustive();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cla_serial_adder.md
Name: cla_serial_adder

Overview:
- Parametrised multi-cycle successor to the 4-bit carry-lookahead adder.
- Adds WIDTH-bit operands one 4-bit CLA slice per clock, LSB slice first, with a registered carry between slices.
- Provides add/subtract mode, start/busy/done handshake, and Cout, Overflow and Zero flags.
- Used where a wide adder must fit a short clock period at the cost of latency.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4.
- NSLICE, WIDTH/4, derived number of 4-bit slices; not overridable.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a new operation; sampled on the rising edge.
- A  input  WIDTH  operand A; sampled only when start is accepted.
- B  input  WIDTH  operand B; sampled only when start is accepted.
- Cin  input  1  carry-in for add mode; ignored when Sub=1.
- Sub  input  1  0 selects A+B+Cin; 1 selects A-B, computed as A+~B+1.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse; results valid.
- Sum  output  WIDTH  result.
- Cout  output  1  carry out of the MSB; in subtract mode, 1 means no borrow.
- Overflow  output  1  signed overflow: carry into MSB XOR carry out of MSB.
- Zero  output  1  Sum == 0.

Behaviour:
- Reset:
  - rst=1 at a rising edge forces state IDLE.
  - busy=0, done=0, Sum=0, Cout=0, Overflow=0, Zero=0 from the next cycle.
  - Reset has priority over start and over an operation in progress.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 latches A, plus B or ~B (per Sub).
  - Carry register loads Cin when Sub=0, 1 when Sub=1.
  - Slice counter loads 0. Next state RUN.
- RUN:
  - Each cycle the 4-bit CLA slice adds operand bits [4k+3:4k] with the carry register.
  - Writes the 4-bit result into internal accumulator bits [4k+3:4k].
  - Updates the carry register and increments k.
  - When k == NSLICE-1 the slice is processed, outputs are registered, and next state is DONE.
  - start is ignored in RUN.
- DONE:
  - done=1 for exactly one cycle; busy=0.
  - If start=1 in DONE, the new operation is accepted exactly as from IDLE (back-to-back) and next state is RUN; otherwise next state is IDLE.
- busy=1 in every RUN cycle, 0 otherwise.
- Latency: start accepted at edge 0 gives busy=1 during cycles 1..NSLICE and done=1 in cycle NSLICE+1. For WIDTH=16, done is in cycle 5.
- Output registers:
  - Sum/Cout/Overflow/Zero update only on the edge entering DONE.
  - They hold their value through IDLE and the following operation until the next completion.
  - Partial slice results never appear on Sum.
- Arithmetic rules:
  - All arithmetic is modulo 2^WIDTH.
  - Overflow uses the carry into bit WIDTH-1, captured from the last slice's internal carry.
  - WIDTH=4 degenerates to a single RUN cycle: done in cycle 2.
- Operand changes on A/B/Cin/Sub after acceptance have no effect on the operation in flight.
- Reset mid-operation: done is never asserted for the aborted operation, and outputs return to 0.

Test Plan:
- Reset, WIDTH=16: hold rst=1 for 2 cycles with start=1 -> busy=0, done=0, Sum=0x0000, all flags 0, no operation started.
- Add: A=0x00FF, B=0x0001, Cin=0, Sub=0 -> busy=1 in cycles 1-4, done=1 in cycle 5 only, Sum=0x0100, Cout=0, Overflow=0, Zero=0.
- Wrap: A=0xFFFF, B=0x0000, Cin=1 -> Sum=0x0000, Cout=1, Zero=1, Overflow=0. Then Sub: A=0x7FFF, B=0xFFFF -> Sum=0x8000, Cout=0, Overflow=1.
- Handshake:
  - Pulse start again in cycle 2 with A=0x1111 -> ignored; the result of the first operation is unchanged.
  - Assert start in the DONE cycle with A=0x0002, B=0x0003 -> accepted; done in the 5th cycle after it, Sum=0x0005.
- Reset mid-operation: start A=0x1234, B=0x1111, then rst=1 in cycle 2 -> busy=0 next cycle, done never pulses, Sum=0x0000.
- Exhaustive/random:
  - WIDTH=4: all 512 A/B/Cin combinations with Sub=0, compared against a+b+c (Sum=[3:0], Cout=[4]), zero mismatches.
  - WIDTH=16: 1000 random add/sub operations with back-to-back starts checked against a reference model.
